// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine for integer-degree angles, Q1.14 outputs.
// Optional build macro CORDIC_ROUND_EN: round-half-up when dropping the guard bits.
module cordic_sincos #(
  parameter int ITERATIONS = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        i_angle,
  output logic signed [15:0] sine_out,
  output logic signed [15:0] cosine_out,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, REDUCE, ROTATE} state_t;

  localparam logic signed [17:0] X0 = 18'sd39797;

  state_t             state_q, state_d;
  logic [15:0]        angle_q, angle_d;
  logic signed [17:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]         it_q, it_d;
  logic               neg_cos_q, neg_cos_d;
  logic signed [15:0] sine_q, sine_d, cosine_q, cosine_d;
  logic               done_q, done_d;

  // atan(2^-i) in degrees with 8 fractional bits
  function automatic logic signed [17:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    return 18'sd11520;
      5'd1:    return 18'sd6801;
      5'd2:    return 18'sd3593;
      5'd3:    return 18'sd1824;
      5'd4:    return 18'sd916;
      5'd5:    return 18'sd458;
      5'd6:    return 18'sd229;
      5'd7:    return 18'sd115;
      5'd8:    return 18'sd57;
      5'd9:    return 18'sd29;
      5'd10:   return 18'sd14;
      5'd11:   return 18'sd7;
      5'd12:   return 18'sd4;
      5'd13:   return 18'sd2;
      5'd14:   return 18'sd1;
      default: return 18'sd0;
    endcase
  endfunction

  function automatic logic signed [17:0] drop_guard(input logic signed [17:0] v);
    logic signed [18:0] t;
`ifdef CORDIC_ROUND_EN
    t = {v[17], v} + 19'sd2;
`else
    t = {v[17], v};
`endif
    return {t[18], t[18:2]};
  endfunction

  function automatic logic signed [15:0] sat(input logic signed [17:0] v);
    if (v > 18'sd16384)       return 16'sd16384;
    else if (v < -18'sd16384) return -16'sd16384;
    else                      return v[15:0];
  endfunction

  logic signed [17:0] theta, zdeg, xs, ys, cx;

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    it_d      = it_q;
    neg_cos_d = neg_cos_q;
    sine_d    = sine_q;
    cosine_d  = cosine_q;
    done_d    = 1'b0;
    theta     = {2'b00, angle_q};
    zdeg      = theta;
    xs        = x_q >>> it_q;
    ys        = y_q >>> it_q;
    cx        = drop_guard(x_q);
    case (state_q)
      IDLE: if (start) begin
        angle_d = i_angle;
        state_d = REDUCE;
      end
      REDUCE: begin
        if (angle_q >= 16'd360) begin
          angle_d = angle_q - 16'd360;
        end else begin
          neg_cos_d = 1'b0;
          if (theta <= 18'sd90) begin
            zdeg = theta;
          end else if (theta <= 18'sd270) begin
            zdeg      = 18'sd180 - theta;
            neg_cos_d = 1'b1;
          end else begin
            zdeg = theta - 18'sd360;
          end
          x_d     = X0;
          y_d     = '0;
          z_d     = zdeg <<< 8;
          it_d    = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        if (it_q == 5'(ITERATIONS)) begin
          sine_d   = sat(drop_guard(y_q));
          cosine_d = sat(neg_cos_q ? -cx : cx);
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          if (!z_q[17]) begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            z_d = z_q - atan_lut(it_q);
          end else begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            z_d = z_q + atan_lut(it_q);
          end
          it_d = it_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      angle_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      it_q      <= '0;
      neg_cos_q <= 1'b0;
      sine_q    <= '0;
      cosine_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      it_q      <= it_d;
      neg_cos_q <= neg_cos_d;
      sine_q    <= sine_d;
      cosine_q  <= cosine_d;
      done_q    <= done_d;
    end
  end

  assign sine_out   = sine_q;
  assign cosine_out = cosine_q;
  assign done       = done_q;
endmodule

// File: tb/tb_cordic_sincos.sv
// Directed-vector bench for cordic_sincos: table of angles, corner sequences, full 0..359 sweep.
module tb_cordic_sincos;
  logic               clk;
  logic               reset;
  logic               start;
  logic [15:0]        i_angle;
  logic signed [15:0] sine_out, cosine_out;
  logic               done;

  int tests = 0;
  int fails = 0;

  cordic_sincos #(.ITERATIONS(14)) dut (
    .clk(clk), .reset(reset), .start(start), .i_angle(i_angle),
    .sine_out(sine_out), .cosine_out(cosine_out), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ang;
    int          exp_sin;
    int          exp_cos;
    int          exp_lat;
  } vec_t;

  task automatic chk_near(input string name, input int act, input int exp);
    tests++;
    if (act - exp > 8 || exp - act > 8) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d +/-8", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns edges from accept to done (-1 on timeout).
  task automatic run_req(input logic [15:0] ang, output int lat,
                         output int s, output int c);
    i_angle = ang;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
    s = sine_out;
    c = cosine_out;
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  initial begin
    vec_t vecs[10];
    int lat, s, c, n, ndone, first;
    real rad;

    vecs[0] = '{16'd0,     0,      16384, 16};
    vecs[1] = '{16'd90,    16384,  0,     16};
    vecs[2] = '{16'd210,   -8192,  -14189, 16};
    vecs[3] = '{16'd359,   -286,   16382, 16};
    vecs[4] = '{16'd450,   16384,  0,     17};
    vecs[5] = '{16'd180,   0,      -16384, 16};
    vecs[6] = '{16'd270,   -16384, 0,     16};
    vecs[7] = '{16'd1000,  -16135, 2845,  18};
    vecs[8] = '{16'd65535, 4240,   15826, 198};
    vecs[9] = '{16'd30,    8192,   14189, 16};

    reset   = 1'b0;
    start   = 1'b0;
    i_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset sine", int'(sine_out), 0);
    chk_eq("reset cos", int'(cosine_out), 0);
    chk_eq("reset done", int'(done), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      run_req(vecs[k].ang, lat, s, c);
      chk_eq($sformatf("lat ang=%0d", vecs[k].ang), lat, vecs[k].exp_lat);
      chk_near($sformatf("sin ang=%0d", vecs[k].ang), s, vecs[k].exp_sin);
      chk_near($sformatf("cos ang=%0d", vecs[k].ang), c, vecs[k].exp_cos);
      @(posedge clk); #1;
    end

    // second start mid-computation must be ignored
    i_angle = 16'd30;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_angle = 16'd200;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 5; ndone = 0; first = -1; s = 0; c = 0;
    while (n < 45) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        ndone++;
        if (first < 0) begin first = n; s = sine_out; c = cosine_out; end
      end
    end
    chk_eq("ignored start done count", ndone, 1);
    chk_eq("ignored start latency", first, 16);
    chk_near("ignored start sin", s, 8192);
    chk_near("ignored start cos", c, 14189);

    // reset mid-computation aborts
    i_angle = 16'd90;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk_eq("abort sine", int'(sine_out), 0);
    chk_eq("abort cos", int'(cosine_out), 0);
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk_eq("abort no done", ndone, 0);
    run_req(16'd60, lat, s, c);
    chk_eq("post-abort lat", lat, 16);
    chk_near("post-abort sin", s, 14189);
    chk_near("post-abort cos", c, 8192);

    // back-to-back sweep, each start issued in the previous done cycle
    @(posedge clk); #1;
    for (int a = 0; a < 360; a++) begin
      run_req(16'(a), lat, s, c);
      rad = real'(a) * 3.14159265358979 / 180.0;
      chk_eq($sformatf("sweep lat %0d", a), lat, 16);
      chk_near($sformatf("sweep sin %0d", a), s, rnd(16384.0 * $sin(rad)));
      chk_near($sformatf("sweep cos %0d", a), c, rnd(16384.0 * $cos(rad)));
    end
    @(posedge clk); #1;
    chk_eq("sweep done drops", int'(done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
